// File: rtl/vocab_matcher.sv
// vocab_matcher: scans a null-padded vocabulary in a sync-read SRAM for one
// input word. Each character comparison costs two cycles: a FETCH cycle that
// issues the read and a CMP cycle that consumes the returned character.
module vocab_matcher #(
    parameter int DATA_WIDTH  = 8,
    parameter int WORD_LENGTH = 3,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_ENTRIES = 5,
    parameter int VOCAB_BASE  = 0,
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    localparam int CNT_W = $clog2(NUM_ENTRIES * WORD_LENGTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] req_word,
    output logic                              mem_rd_en,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic                              res_hit,
    output logic [IDX_W-1:0]                  res_index,
    output logic [CNT_W-1:0]                  res_compares
);

    localparam int KW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

    // The vocabulary window must fit inside the SRAM address space.
    if (NUM_ENTRIES * WORD_LENGTH + VOCAB_BASE > 2 ** ADDR_WIDTH) begin : g_cfg_check
        $error("vocab_matcher: vocabulary does not fit in ADDR_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CMP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                            r_state;
    state_t                            w_state_next;
    logic [WORD_LENGTH*DATA_WIDTH-1:0] r_word;
    logic [IDX_W-1:0]                  r_e;
    logic [IDX_W-1:0]                  w_e_next;
    logic [KW-1:0]                     r_k;
    logic [KW-1:0]                     w_k_next;
    logic [CNT_W-1:0]                  r_cnt;
    logic [CNT_W-1:0]                  w_cnt_next;
    logic [ADDR_WIDTH-1:0]             r_entry_addr;   // address of current entry, char 0
    logic [ADDR_WIDTH-1:0]             w_entry_addr_next;
    logic [ADDR_WIDTH-1:0]             r_mem_addr;
    logic [ADDR_WIDTH-1:0]             w_mem_addr_next;
    logic                              r_hit;
    logic                              w_hit_next;
    logic [IDX_W-1:0]                  r_index;
    logic [IDX_W-1:0]                  w_index_next;
    logic                              w_latch;

    logic [DATA_WIDTH-1:0]             w_chars [WORD_LENGTH];
    logic [DATA_WIDTH-1:0]             w_cur_char;
    logic                              w_last_entry;
    logic                              w_last_char;

    // Unpack the latched word into per-character lanes.
    for (genvar gi = 0; gi < WORD_LENGTH; gi++) begin : g_chars
        assign w_chars[gi] = r_word[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_cur_char   = w_chars[r_k];
    assign w_last_entry = (r_e == IDX_W'(NUM_ENTRIES - 1));
    assign w_last_char  = (r_k == KW'(WORD_LENGTH - 1));

    assign req_ready    = (r_state == S_IDLE);
    assign res_valid    = (r_state == S_DONE);
    assign mem_rd_en    = (r_state == S_FETCH);
    assign mem_addr     = r_mem_addr;
    assign res_hit      = r_hit;
    assign res_index    = r_index;
    assign res_compares = r_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and search datapath decisions; the compare order matters
    // (end-of-vocab null is tested before mismatch).
    always_comb begin
        w_state_next      = r_state;
        w_e_next          = r_e;
        w_k_next          = r_k;
        w_cnt_next        = r_cnt;
        w_entry_addr_next = r_entry_addr;
        w_mem_addr_next   = r_mem_addr;
        w_hit_next        = r_hit;
        w_index_next      = r_index;
        w_latch           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_latch           = 1'b1;
                    w_e_next          = '0;
                    w_k_next          = '0;
                    w_cnt_next        = '0;
                    w_hit_next        = 1'b0;
                    w_index_next      = '0;
                    w_entry_addr_next = ADDR_WIDTH'(VOCAB_BASE);
                    if (req_word[DATA_WIDTH-1:0] == '0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next    = S_FETCH;
                        w_mem_addr_next = ADDR_WIDTH'(VOCAB_BASE);
                    end
                end
            end
            S_FETCH: begin
                w_state_next = S_CMP;
            end
            S_CMP: begin
                w_cnt_next = r_cnt + CNT_W'(1);
                if (r_k == '0 && mem_rdata == '0) begin
                    w_state_next = S_DONE;
                end else if (mem_rdata != w_cur_char) begin
                    if (w_last_entry) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_e_next          = r_e + IDX_W'(1);
                        w_k_next          = '0;
                        w_entry_addr_next = r_entry_addr + ADDR_WIDTH'(WORD_LENGTH);
                        w_mem_addr_next   = r_entry_addr + ADDR_WIDTH'(WORD_LENGTH);
                        w_state_next      = S_FETCH;
                    end
                end else if (mem_rdata == '0 || w_last_char) begin
                    w_hit_next   = 1'b1;
                    w_index_next = r_e;
                    w_state_next = S_DONE;
                end else begin
                    w_k_next        = r_k + KW'(1);
                    w_mem_addr_next = r_entry_addr + ADDR_WIDTH'(r_k) + ADDR_WIDTH'(1);
                    w_state_next    = S_FETCH;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Search datapath registers; reset clears any in-flight search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word       <= '0;
            r_e          <= '0;
            r_k          <= '0;
            r_cnt        <= '0;
            r_entry_addr <= '0;
            r_mem_addr   <= '0;
            r_hit        <= 1'b0;
            r_index      <= '0;
        end else begin
            if (w_latch) begin
                r_word <= req_word;
            end
            r_e          <= w_e_next;
            r_k          <= w_k_next;
            r_cnt        <= w_cnt_next;
            r_entry_addr <= w_entry_addr_next;
            r_mem_addr   <= w_mem_addr_next;
            r_hit        <= w_hit_next;
            r_index      <= w_index_next;
        end
    end

endmodule
